accel_mem_sequencer: RTL and testbench

// - Accelerator-side client of cpu_datamem (lowest-priority ACCEL port): fetches one 512-bit message block, hands it to the hash core, writes the 256-bit digest back.
// - Digest goes back as eight 32-bit words; CPU is signalled on completion.
// - Sits between cpu_datamem (accel_addr/accel_wrt_*/accel_rd_data) and the SHA-256 core (valid/ready handshakes).

---
 rtl/accel_seq_pkg.sv | 24 ++
 rtl/accel_mem_sequencer_serializer.sv | 51 +++++
 rtl/accel_mem_sequencer.sv | 137 +++++++++++++
 tb/tb_accel_mem_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_seq_pkg.sv
// Shared types and constants for the accelerator memory sequencer.
package accel_seq_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int BLOCK_BITS   = 512;
  localparam int DIGEST_BITS  = 256;
  localparam int WORD_BITS    = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    SEND     = 3'd3,
    WAIT_DIG = 3'd4,
    WRITE    = 3'd5,
    DONE     = 3'd6
  } seq_state_t;

  // Byte offset of digest word idx from the destination base address.
  function automatic logic [4:0] word_byte_off(input logic [2:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/accel_mem_sequencer_serializer.sv
// Holds the latched 256-bit digest and walks it out as eight 32-bit words,
// most significant word first.
module digest_serializer
  import accel_seq_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DIGEST_BITS-1:0] digest_in,
  input  logic                   commit,
  output logic [WORD_BITS-1:0]   word_data,
  output logic [ADDR_W-1:0]      word_addr_off,
  output logic                   last_word
);

  logic [DIGEST_BITS-1:0] dig_q, dig_d;
  logic [2:0]             idx_q, idx_d;

  // Next-state: load restarts at word 0, each commit advances one word.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    dig_d = dig_q;
    idx_d = idx_q;
    if (load) begin
      dig_d = digest_in;
      idx_d = 3'd0;
    end else if (commit) begin
      idx_d = idx_q + 3'd1;
    end
  end

  // Word index register; cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) idx_q <= 3'd0;
    else     idx_q <= idx_d;
  end

  // Digest data register.
  // NOTE: pure datapath storage, only read after a load, so it carries no reset.
  always_ff @(posedge clk) begin
    dig_q <= dig_d;
  end

  assign word_data     = dig_q[(DIGEST_BITS-1) - WORD_BITS*int'(idx_q) -: WORD_BITS];
  assign word_addr_off = ADDR_W'(word_byte_off(idx_q));
  assign last_word     = (idx_q == 3'(DIGEST_WORDS-1));

endmodule

// File: rtl/accel_mem_sequencer.sv
// Accelerator-side datamem client: reads one 64-byte block, hands it to the
// hash core, then writes the 32-byte digest back as eight words.
module accel_mem_sequencer
  import accel_seq_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      src_addr,
  input  logic [ADDR_W-1:0]      dst_addr,
  input  logic                   mem_busy,
  output logic [ADDR_W-1:0]      accel_addr,
  output logic [WORD_BITS-1:0]   accel_wrt_data,
  output logic                   accel_wrt_en,
  input  logic [BLOCK_BITS-1:0]  accel_rd_data,
  output logic [BLOCK_BITS-1:0]  blk_data,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  input  logic [DIGEST_BITS-1:0] digest,
  input  logic                   digest_valid,
  output logic                   digest_ready,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  seq_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     src_q, src_d;
  logic [ADDR_W-1:0]     dst_q, dst_d;
  logic [1:0]            lat_q, lat_d;
  logic [BLOCK_BITS-1:0] blk_q, blk_d;

  logic                  commit;
  logic                  load;
  logic [WORD_BITS-1:0]  word_data;
  logic [ADDR_W-1:0]     word_addr_off;
  logic                  last_word;

  assign commit = (state_q == WRITE) && !mem_busy;
  assign load   = (state_q == WAIT_DIG) && digest_valid;

  digest_serializer #(.ADDR_W(ADDR_W)) u_ser (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .digest_in     (digest),
    .commit        (commit),
    .word_data     (word_data),
    .word_addr_off (word_addr_off),
    .last_word     (last_word)
  );

  // Sequencer FSM next-state and address/block capture.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    lat_d   = lat_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        // Losing arbitration just retries the request next cycle.
        if (!mem_busy) begin
          lat_d   = 2'd0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          blk_d   = accel_rd_data;
          state_d = SEND;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND:     if (blk_ready)          state_d = WAIT_DIG;
      WAIT_DIG: if (digest_valid)       state_d = WRITE;
      WRITE:    if (commit && last_word) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and job registers; reset drops any in-flight job without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      lat_q   <= 2'd0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      lat_q   <= lat_d;
      blk_q   <= blk_d;
    end
  end

  // Outputs decoded from the current state; everything idles at zero.
  always_comb begin
    accel_addr     = '0;
    accel_wrt_data = '0;
    accel_wrt_en   = 1'b0;
    blk_valid      = 1'b0;
    digest_ready   = 1'b0;
    done           = 1'b0;
    case (state_q)
      RD_REQ, RD_WAIT: accel_addr = src_q;
      SEND:            blk_valid = 1'b1;
      WAIT_DIG:        digest_ready = 1'b1;
      WRITE: begin
        accel_wrt_en   = 1'b1;
        accel_addr     = dst_q + word_addr_off;
        accel_wrt_data = word_data;
      end
      DONE:            done = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign blk_data = blk_q;

endmodule

// File: tb/tb_accel_mem_sequencer.sv
// Scoreboard bench for accel_mem_sequencer with a byte-addressed datamem model.
module tb_accel_mem_sequencer;
  import accel_seq_pkg::*;

  localparam int RD_LATENCY = 1;
  localparam int ADDR_W     = 16;

  localparam logic [255:0] DIG1 = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] DIG2 = 256'h10203040_50607080_90A0B0C0_D0E0F001_12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
  localparam logic [255:0] DIG3 = 256'hCAFEF00D_0BADBEEF_11223344_55667788_99AABBCC_DDEEFF00_A5A5A5A5_5A5A5A5A;
  localparam logic [255:0] DIG4 = 256'h01010101_02020202_03030303_04040404_05050505_06060606_07070707_08080808;
  localparam logic [255:0] DIG5 = 256'hF0000000_F1000000_F2000000_F3000000_F4000000_F5000000_F6000000_F7000000;
  localparam logic [255:0] DIG6 = 256'h00000A01_00000A02_00000A03_00000A04_00000A05_00000A06_00000A07_00000A08;
  localparam logic [255:0] DIG7 = 256'h77770000_77770001_77770002_77770003_77770004_77770005_77770006_77770007;
  localparam logic [255:0] JUNK = {8{32'hDEADDEAD}};

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [ADDR_W-1:0]      src_addr, dst_addr;
  logic                   mem_busy;
  logic [ADDR_W-1:0]      accel_addr;
  logic [31:0]            accel_wrt_data;
  logic                   accel_wrt_en;
  logic [511:0]           accel_rd_data;
  logic [511:0]           blk_data;
  logic                   blk_valid, blk_ready;
  logic [255:0]           digest;
  logic                   digest_valid, digest_ready;
  logic                   busy, done;

  always #5 clk = ~clk;

  accel_mem_sequencer #(.RD_LATENCY(RD_LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .mem_busy(mem_busy), .accel_addr(accel_addr), .accel_wrt_data(accel_wrt_data),
    .accel_wrt_en(accel_wrt_en), .accel_rd_data(accel_rd_data), .blk_data(blk_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .digest(digest),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy), .done(done)
  );

  // ---------------- datamem model ----------------
  bit   [7:0]   mem [0:65535];
  logic [511:0] rd_pipe [RD_LATENCY];

  // Read-side contents: a fixed pattern derived from each byte address.
  function automatic logic [511:0] src_block(input logic [15:0] a);
    logic [511:0] b;
    logic [15:0]  ai;
    for (int i = 0; i < 64; i++) begin
      ai = a + 16'(i);
      b[8*i +: 8] = ai[7:0] ^ ai[15:8] ^ 8'hA5;
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (!rst && accel_wrt_en && !mem_busy)
      for (int b = 0; b < 4; b++) mem[accel_addr + 16'(b)] <= accel_wrt_data[8*b +: 8];
    rd_pipe[0] <= mem_busy ? {16{32'hDEADBEEF}} : src_block(accel_addr);
    for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign accel_rd_data = rd_pipe[RD_LATENCY-1];

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
  wr_t          wr_q[$];
  int           done_q[$];
  logic [511:0] blk_q[$];
  logic [15:0]  addr_log[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic         prev_wr_stall = 1'b0;
  logic [15:0]  prev_addr;
  logic [31:0]  prev_data;
  logic         prev_blk_wait = 1'b0;
  logic [511:0] prev_blk;
  logic         dig_taken = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_wr_stall = 1'b0;
      prev_blk_wait = 1'b0;
      dig_taken     = 1'b0;
    end else begin
      if (blk_valid || digest_ready) begin
        check("blk_dig_exclusive", 64'(blk_valid && digest_ready), 64'(0));
        check("no_wr_in_handshake", 64'(accel_wrt_en), 64'(0));
      end
      if (prev_blk_wait) check_blk("blk_stable", blk_data, prev_blk);
      if (blk_valid && blk_ready) begin
        check("blk_expected", 64'(blk_q.size() > 0), 64'(1));
        if (blk_q.size() > 0) check_blk("blk_data", blk_data, blk_q.pop_front());
      end
      prev_blk_wait = blk_valid && !blk_ready;
      prev_blk      = blk_data;
      if (digest_valid && digest_ready) dig_taken = 1'b1;

      if (prev_wr_stall) begin
        check("stall_en", 64'(accel_wrt_en), 64'(1));
        check("stall_addr", 64'(accel_addr), 64'(prev_addr));
        check("stall_data", 64'(accel_wrt_data), 64'(prev_data));
      end
      if (accel_wrt_en) begin
        check("wr_after_digest", 64'(dig_taken), 64'(1));
        if (!mem_busy) begin
          addr_log.push_back(accel_addr);
          check("wr_expected", 64'(wr_q.size() > 0), 64'(1));
          if (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            check("wr_addr", 64'(accel_addr), 64'(e.addr));
            check("wr_data", 64'(accel_wrt_data), 64'(e.data));
          end
        end
      end
      prev_wr_stall = accel_wrt_en && mem_busy;
      prev_addr     = accel_addr;
      prev_data     = accel_wrt_data;

      if (done) begin
        check("done_expected", 64'(done_q.size() > 0), 64'(1));
        if (done_q.size() > 0) check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        dig_taken = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Pulse start and push the whole expected response of the job.
  task automatic run_start(input logic [15:0] src, input logic [15:0] dst,
                           input logic [255:0] dig, input int extra);
    wr_t e;
    @(posedge clk); #1;
    start    = 1'b1;
    src_addr = src;
    dst_addr = dst;
    blk_q.push_back(src_block(src));
    for (int w = 0; w < 8; w++) begin
      e.addr = dst + 16'(4*w);
      e.data = dig[255 - 32*w -: 32];
      wr_q.push_back(e);
    end
    done_q.push_back(cyc + RD_LATENCY + 12 + extra);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_q.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_in_time", 64'(done_q.size() == 0), 64'(1));
  endtask

  task automatic wait_words_left(input int left, input int budget);
    int n = 0;
    while (wr_q.size() != left && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("word_progress", 64'(wr_q.size()), 64'(left));
  endtask

  task automatic wait_blk_valid(input int budget);
    int n = 0;
    while (!blk_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("blk_valid_seen", 64'(blk_valid), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] wrap_addrs [8] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004,
                                  16'h0008, 16'h000C, 16'h0010, 16'h0014};

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; mem_busy = 1'b0;
    blk_ready = 1'b1; digest_valid = 1'b1; digest = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wrt_en", 64'(accel_wrt_en), 64'(0));
    check("rst_addr", 64'(accel_addr), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_blk_valid", 64'(blk_valid), 64'(0));
    check("rst_digest_ready", 64'(digest_ready), 64'(0));
    check_blk("rst_blk_data", blk_data, 512'(0));

    // Basic job: little-endian words 1..8 at 0x100
    digest = DIG1;
    run_start(16'h0040, 16'h0100, DIG1, 0);
    wait_done(100);
    for (int i = 0; i < 32; i++)
      check("mem_basic", 64'(mem[16'h0100 + 16'(i)]), 64'((i % 4 == 0) ? (i / 4 + 1) : 0));

    // Contention: 5 busy cycles in RD_REQ, 3 on word 4
    digest = DIG2;
    run_start(16'h0080, 16'h0200, DIG2, 8);
    mem_busy = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    mem_busy = 1'b0;
    wait_words_left(4, 100);
    mem_busy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_busy = 1'b0;
    wait_done(100);
    check("mem_contention_w4", 64'(mem_word(16'h0210)), 64'(32'h12345678));

    // Handshake stall: blk_ready late by 10, digest_valid late by 6
    blk_ready = 1'b0; digest_valid = 1'b0; digest = JUNK;
    run_start(16'h00C0, 16'h0300, DIG3, 16);
    wait_blk_valid(50);
    repeat (10) begin @(posedge clk); #1; end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    check("wait_dig_ready", 64'(digest_ready), 64'(1));
    repeat (6) begin @(posedge clk); #1; end
    digest = DIG3; digest_valid = 1'b1;
    wait_done(100);
    blk_ready = 1'b1;

    // Address wrap at the top of the 16-bit space
    addr_log.delete();
    digest = DIG4;
    run_start(16'hFFE0, 16'hFFF8, DIG4, 0);
    wait_done(100);
    check("wrap_count", 64'(addr_log.size()), 64'(8));
    for (int w = 0; w < 8 && w < addr_log.size(); w++)
      check("wrap_addr", 64'(addr_log[w]), 64'(wrap_addrs[w]));
    for (int w = 0; w < 8; w++)
      check("wrap_mem", 64'(mem_word(wrap_addrs[w])), 64'(DIG4[255 - 32*w -: 32]));

    // Reset in the middle of WRITE, right after word 3
    digest = DIG5;
    run_start(16'h0140, 16'h0400, DIG5, 0);
    wait_words_left(4, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_q.delete(); done_q.delete(); blk_q.delete();
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_wrt_en", 64'(accel_wrt_en), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    repeat (5) begin @(posedge clk); #1; end
    check("rst_mid_w3", 64'(mem_word(16'h040C)), 64'(32'hF3000000));
    check("rst_mid_w4", 64'(mem_word(16'h0410)), 64'(0));
    digest = DIG6;
    run_start(16'h0180, 16'h0500, DIG6, 0);
    wait_done(100);
    check("fresh_w7", 64'(mem_word(16'h051C)), 64'(32'h00000A08));

    // Start pulse while busy in SEND is ignored
    blk_ready = 1'b0; digest = DIG7;
    run_start(16'h01C0, 16'h0600, DIG7, 1);
    wait_blk_valid(50);
    start = 1'b1; src_addr = 16'h0240; dst_addr = 16'h0700;
    @(posedge clk); #1;
    start = 1'b0; blk_ready = 1'b1;
    wait_done(100);
    repeat (20) begin @(posedge clk); #1; end
    check("ignored_start_idle", 64'(busy), 64'(0));
    check("ignored_dst_untouched", 64'(mem_word(16'h0700)), 64'(0));
    check("orig_dst_w0", 64'(mem_word(16'h0600)), 64'(32'h77770000));

    check("wr_q_drained", 64'(wr_q.size()), 64'(0));
    check("done_q_drained", 64'(done_q.size()), 64'(0));
    check("blk_q_drained", 64'(blk_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
